max7219_display_ctrl: RTL and testbench

//   Sequencer driving one MAX7219 serial-shift block: runs the chip init sequence after reset,

---
 rtl/max7219_display_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_max7219_display_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_display_ctrl.sv
// MAX7219 sequencer: chip init, full refresh, then pushes only changed digits,
// intensity and shutdown updates as single register writes to a serial shifter.
module max7219_display_ctrl #(
  parameter int         DIGITS    = 8,
  parameter logic [7:0] DECODE    = 8'h00,
  parameter logic [3:0] INTENSITY = 4'h8,
  parameter int         BUSY_WAIT = 4
) (
  input  logic       clki,
  input  logic       reset,
  input  logic       wr,
  input  logic [2:0] wr_digit,
  input  logic [7:0] wr_data,
  input  logic       int_wr,
  input  logic [3:0] int_value,
  input  logic       shutdown,
  output logic       set,
  output logic [3:0] address,
  output logic [7:0] data,
  input  logic       busy,
  output logic       init_done,
  output logic       idle,
  output logic       err
);

  localparam int         CW        = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [3:0] DIG_N     = 4'(DIGITS);
  localparam logic [7:0] DIRTY_ALL = 8'((1 << DIGITS) - 1);

  typedef enum logic [1:0] {T_INIT, T_REFRESH, T_IDLE} top_e;
  typedef enum logic [1:0] {X_DECIDE, X_ISSUE, X_WAIT_HI, X_WAIT_LO} xfer_e;

  top_e          top_q, top_d;
  xfer_e         xs_q, xs_d;
  logic [2:0]    step_q, step_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    dirty_q, dirty_d;
  logic [7:0]    buf_q [8];
  logic [7:0]    buf_d [8];
  logic [3:0]    int_val_q, int_val_d;
  logic          int_pend_q, int_pend_d;
  logic          shut_sent_q, shut_sent_d;

  logic          dig_found;
  logic [2:0]    dig_sel;
  logic [3:0]    init_addr;
  logic [7:0]    init_data;

  always_comb begin
    dig_found = 1'b0;
    dig_sel   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!dig_found && dirty_q[3'(i)]) begin
        dig_found = 1'b1;
        dig_sel   = 3'(i);
      end
    end
  end

  always_comb begin
    case (step_q)
      3'd0:    begin init_addr = 4'hF; init_data = 8'h00;               end
      3'd1:    begin init_addr = 4'hB; init_data = 8'(DIGITS - 1);      end
      3'd2:    begin init_addr = 4'h9; init_data = DECODE;              end
      3'd3:    begin init_addr = 4'hA; init_data = {4'h0, INTENSITY};   end
      default: begin init_addr = 4'hC; init_data = {7'h00, ~shutdown};  end
    endcase
  end

  always_comb begin
    top_d       = top_q;
    xs_d        = xs_q;
    step_d      = step_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    err_d       = err_q;
    dirty_d     = dirty_q;
    buf_d       = buf_q;
    int_val_d   = int_val_q;
    int_pend_d  = int_pend_q;
    shut_sent_d = shut_sent_q;

    // Dirty/pending flags drop as ISSUE is entered; the strobe handling below
    // runs afterwards so a same-cycle write re-arms them.
    case (xs_q)
      X_DECIDE: begin
        case (top_q)
          T_INIT: begin
            if (step_q <= 3'd4) begin
              addr_d = init_addr;
              data_d = init_data;
              step_d = step_q + 3'd1;
              xs_d   = X_ISSUE;
              if (step_q == 3'd4) shut_sent_d = shutdown;
            end else begin
              top_d = T_REFRESH;
            end
          end
          T_REFRESH: begin
            if (dig_found) begin
              addr_d           = {1'b0, dig_sel} + 4'd1;
              data_d           = buf_q[dig_sel];
              dirty_d[dig_sel] = 1'b0;
              xs_d             = X_ISSUE;
            end else begin
              done_d = 1'b1;
              top_d  = T_IDLE;
            end
          end
          default: begin
            if (shutdown != shut_sent_q) begin
              addr_d      = 4'hC;
              data_d      = {7'h00, ~shutdown};
              shut_sent_d = shutdown;
              xs_d        = X_ISSUE;
            end else if (int_pend_q) begin
              addr_d     = 4'hA;
              data_d     = {4'h0, int_val_q};
              int_pend_d = 1'b0;
              xs_d       = X_ISSUE;
            end else if (dig_found) begin
              addr_d           = {1'b0, dig_sel} + 4'd1;
              data_d           = buf_q[dig_sel];
              dirty_d[dig_sel] = 1'b0;
              xs_d             = X_ISSUE;
            end
          end
        endcase
      end
      X_ISSUE: begin
        cnt_d = '0;
        xs_d  = X_WAIT_HI;
      end
      X_WAIT_HI: begin
        if (busy) begin
          xs_d = X_WAIT_LO;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          err_d = 1'b1;
          xs_d  = X_DECIDE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (!busy) xs_d = X_DECIDE;
      end
    endcase

    if (int_wr) begin
      int_val_d  = int_value;
      int_pend_d = 1'b1;
    end
    if (wr && ({1'b0, wr_digit} < DIG_N)) begin
      dirty_d[wr_digit] = 1'b1;
      buf_d[wr_digit]   = wr_data;
    end
  end

  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      top_q       <= T_INIT;
      xs_q        <= X_DECIDE;
      step_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dirty_q     <= DIRTY_ALL;
      buf_q       <= '{default: '0};
      int_val_q   <= INTENSITY;
      int_pend_q  <= 1'b0;
      shut_sent_q <= 1'b1;
    end else begin
      top_q       <= top_d;
      xs_q        <= xs_d;
      step_q      <= step_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      dirty_q     <= dirty_d;
      buf_q       <= buf_d;
      int_val_q   <= int_val_d;
      int_pend_q  <= int_pend_d;
      shut_sent_q <= shut_sent_d;
    end
  end

  assign set       = (xs_q == X_ISSUE);
  assign address   = addr_q;
  assign data      = data_q;
  assign init_done = done_q;
  assign err       = err_q;
  assign idle      = (top_q == T_IDLE) && (xs_q == X_DECIDE) && (dirty_q == '0) &&
                     !int_pend_q && (shutdown == shut_sent_q);

endmodule

// File: tb/tb_max7219_display_ctrl.sv
// Directed bench for max7219_display_ctrl: default 8-digit build plus a 4-digit build,
// each with a simple shifter model answering set with a busy pulse.
`timescale 1ns/1ps
module tb_max7219_display_ctrl;

  logic       clki = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic [2:0] wr_digit = '0;
  logic [7:0] wr_data = '0;
  logic       int_wr = 1'b0;
  logic [3:0] int_value = '0;
  logic       shutdown = 1'b0;
  logic       set;
  logic [3:0] address;
  logic [7:0] data;
  logic       busy;
  logic       init_done, idle, err;

  logic       rst4 = 1'b0;
  logic       wr4 = 1'b0;
  logic [2:0] wr4_digit = '0;
  logic [7:0] wr4_data = '0;
  logic       int_wr4 = 1'b0;
  logic [3:0] int_value4 = '0;
  logic       shutdown4 = 1'b0;
  logic       set4;
  logic [3:0] addr4;
  logic [7:0] data4;
  logic       busy4;
  logic       done4, idle4, err4;

  int checks = 0;
  int errors = 0;

  logic [5:0]  busy_len = 6'd32;
  logic        no_busy  = 1'b0;
  logic [5:0]  bcnt, bcnt4;
  logic [11:0] log_q [$];
  logic [11:0] log4_q [$];
  logic [11:0] held;
  logic        set_prev;
  int          dbl_set = 0;
  int          unstable = 0;

  logic [11:0] e1 [13] = '{12'hF00, 12'hB07, 12'h900, 12'hA08, 12'hC01,
                           12'h100, 12'h200, 12'h300, 12'h400,
                           12'h500, 12'h600, 12'h700, 12'h800};
  logic [11:0] e4 [9]  = '{12'hF00, 12'hB03, 12'h900, 12'hA08, 12'hC01,
                           12'h100, 12'h200, 12'h300, 12'h400};

  max7219_display_ctrl u_dut (
    .clki(clki), .reset(reset), .wr(wr), .wr_digit(wr_digit), .wr_data(wr_data),
    .int_wr(int_wr), .int_value(int_value), .shutdown(shutdown),
    .set(set), .address(address), .data(data), .busy(busy),
    .init_done(init_done), .idle(idle), .err(err)
  );

  max7219_display_ctrl #(.DIGITS(4)) u_dut4 (
    .clki(clki), .reset(rst4), .wr(wr4), .wr_digit(wr4_digit), .wr_data(wr4_data),
    .int_wr(int_wr4), .int_value(int_value4), .shutdown(shutdown4),
    .set(set4), .address(addr4), .data(data4), .busy(busy4),
    .init_done(done4), .idle(idle4), .err(err4)
  );

  always #5 clki = ~clki;

  always @(posedge clki or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      bcnt <= '0;
    end else if (set && !no_busy) begin
      busy <= 1'b1;
      bcnt <= busy_len;
    end else if (bcnt != 6'd0) begin
      if (bcnt == 6'd1) busy <= 1'b0;
      bcnt <= bcnt - 6'd1;
    end
  end

  always @(posedge clki or negedge rst4) begin
    if (!rst4) begin
      busy4 <= 1'b0;
      bcnt4 <= '0;
    end else if (set4) begin
      busy4 <= 1'b1;
      bcnt4 <= 6'd2;
    end else if (bcnt4 != 6'd0) begin
      if (bcnt4 == 6'd1) busy4 <= 1'b0;
      bcnt4 <= bcnt4 - 6'd1;
    end
  end

  always @(posedge clki) begin
    if (reset && set) log_q.push_back({address, data});
    if (reset && set && set_prev) dbl_set <= dbl_set + 1;
    if (reset && busy && ({address, data} != held)) unstable <= unstable + 1;
    if (set) held <= {address, data};
    set_prev <= set;
    if (rst4 && set4) log4_q.push_back({addr4, data4});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lg(input int i);
    return (i < log_q.size()) ? {20'h0, log_q[i]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] lg4(input int i);
    return (i < log4_q.size()) ? {20'h0, log4_q[i]} : 32'hDEAD;
  endfunction

  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n;
    n = 0;
    tick();
    tick();
    while (!idle && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(idle), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_set", 32'(set), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // 1) init + full refresh
    reset = 1'b1;
    rst4  = 1'b1;
    wait_idle(1500, "t1_idle");
    chk("t1_count", 32'(log_q.size()), 32'd13);
    for (int i = 0; i < 13; i++) chk($sformatf("t1_w%0d", i), lg(i), {20'h0, e1[i]});
    chk("t1_done", 32'(init_done), 32'd1);

    // 4-digit build: scan limit 3, only digits 1..4; out-of-range write ignored
    chk("d4_count", 32'(log4_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("d4_w%0d", i), lg4(i), {20'h0, e4[i]});
    chk("d4_done", 32'(done4), 32'd1);
    wr4 = 1'b1; wr4_digit = 3'd5; wr4_data = 8'hEE;
    tick();
    wr4 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("d4_ign_count", 32'(log4_q.size()), 32'd9);
    chk("d4_ign_idle", 32'(idle4), 32'd1);
    wr4 = 1'b1; wr4_digit = 3'd3; wr4_data = 8'h9C;
    tick();
    wr4 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("d4_d3_count", 32'(log4_q.size()), 32'd10);
    chk("d4_d3_word", lg4(9), 32'h49C);

    // 2) single digit update, 2-cycle latency
    busy_len = 6'd6;
    log_q.delete();
    wr = 1'b1; wr_digit = 3'd3; wr_data = 8'h5A;
    tick();
    wr = 1'b0;
    chk("t2_idle_drop", 32'(idle), 32'd0);
    chk("t2_set_early", 32'(set), 32'd0);
    tick();
    chk("t2_set", 32'(set), 32'd1);
    chk("t2_addr", 32'(address), 32'h4);
    chk("t2_data", 32'(data), 32'h5A);
    wait_idle(200, "t2_idle");
    chk("t2_count", 32'(log_q.size()), 32'd1);
    chk("t2_word", lg(0), 32'h45A);

    // 3) intensity coalescing plus same-cycle digit write
    log_q.delete();
    wr = 1'b1; wr_digit = 3'd5; wr_data = 8'h22;
    tick();
    wr = 1'b0;
    tick();
    tick();
    int_wr = 1'b1; int_value = 4'h3;
    tick();
    int_value = 4'h7;
    wr = 1'b1; wr_digit = 3'd0; wr_data = 8'h11;
    tick();
    int_wr = 1'b0;
    wr = 1'b0;
    wait_idle(200, "t3_idle");
    chk("t3_count", 32'(log_q.size()), 32'd3);
    chk("t3_w0", lg(0), 32'h622);
    chk("t3_w1", lg(1), 32'hA07);
    chk("t3_w2", lg(2), 32'h111);

    // 4) shutdown pre-empts a queued digit
    log_q.delete();
    wr = 1'b1; wr_digit = 3'd6; wr_data = 8'h33;
    tick();
    wr_digit = 3'd7; wr_data = 8'h44;
    tick();
    wr = 1'b0;
    tick();
    tick();
    shutdown = 1'b1;
    wait_idle(200, "t4_idle");
    chk("t4_count", 32'(log_q.size()), 32'd3);
    chk("t4_w0", lg(0), 32'h733);
    chk("t4_w1", lg(1), 32'hC00);
    chk("t4_w2", lg(2), 32'h844);
    shutdown = 1'b0;
    wait_idle(200, "t4_idle2");
    chk("t4_count2", 32'(log_q.size()), 32'd4);
    chk("t4_w3", lg(3), 32'hC01);

    // 5) busy never rises
    log_q.delete();
    no_busy = 1'b1;
    wr = 1'b1; wr_digit = 3'd2; wr_data = 8'h77;
    tick();
    wr_digit = 3'd4; wr_data = 8'h55;
    tick();
    wr = 1'b0;
    chk("t5_set", 32'(set), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_err_pre", 32'(err), 32'd0);
    tick();
    chk("t5_err", 32'(err), 32'd1);
    wait_idle(200, "t5_idle");
    chk("t5_count", 32'(log_q.size()), 32'd2);
    chk("t5_w0", lg(0), 32'h377);
    chk("t5_w1", lg(1), 32'h555);
    chk("t5_err_sticky", 32'(err), 32'd1);
    reset = 1'b0;
    tick();
    tick();
    chk("t5_rst_err", 32'(err), 32'd0);
    chk("t5_rst_set", 32'(set), 32'd0);
    chk("t5_rst_idle", 32'(idle), 32'd0);
    chk("t5_rst_done", 32'(init_done), 32'd0);
    no_busy = 1'b0;

    // 6) reset during refresh restarts the init sequence
    log_q.delete();
    reset = 1'b1;
    begin
      int n;
      n = 0;
      while (!(set && log_q.size() == 7) && n < 800) begin
        tick();
        n++;
      end
    end
    chk("t6_reach", 32'(set), 32'd1);
    chk("t6_addr_mid", 32'(address), 32'h3);
    chk("t6_done_mid", 32'(init_done), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_set_low", 32'(set), 32'd0);
    chk("t6_addr_low", 32'(address), 32'd0);
    chk("t6_data_low", 32'(data), 32'd0);
    tick();
    reset = 1'b1;
    log_q.delete();
    wait_idle(1500, "t6_idle");
    chk("t6_count", 32'(log_q.size()), 32'd13);
    for (int i = 0; i < 13; i++) chk($sformatf("t6_w%0d", i), lg(i), {20'h0, e1[i]});
    chk("t6_done", 32'(init_done), 32'd1);

    chk("set_one_cycle", 32'(dbl_set), 32'd0);
    chk("addr_data_stable", 32'(unstable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
